// File: rtl/ra_pq_gen_pkg.sv
// ra_pq_gen_pkg: shared types and the ordering helper for the register-array
// priority queue.
//   pq_mode_e  - single-cycle vs alternating-cycle operation
//   pq_phase_e - accept/sort phase of the alternating-cycle mode
//   pq_better  - 1 when entry a belongs at the lower (closer-to-head) index
package ra_pq_gen_pkg;

    typedef enum logic {
        PQ_SINGLE    = 1'b0,
        PQ_TWO_PHASE = 1'b1
    } pq_mode_e;

    typedef enum logic {
        PH_ACCEPT = 1'b0,
        PH_SORT   = 1'b1
    } pq_phase_e;

    // Widest key the helper can compare; narrower keys are zero-extended.
    localparam int unsigned PQ_KEY_MAX_W = 64;

    // Strict ordering: equal valid keys return 0 so ties never swap.
    // An invalid entry is worse than any valid key in both orderings.
    function automatic logic pq_better(
        input logic                    va,
        input logic [PQ_KEY_MAX_W-1:0] ka,
        input logic                    vb,
        input logic [PQ_KEY_MAX_W-1:0] kb,
        input logic                    max_first
    );
        logic r;
        if (!va) begin
            r = 1'b0;
        end else if (!vb) begin
            r = 1'b1;
        end else if (max_first) begin
            r = (ka > kb);
        end else begin
            r = (ka < kb);
        end
        return r;
    endfunction

endpackage

// File: rtl/ra_pq_gen_if.sv
// ra_pq_gen_if: request/response bundle of the priority queue.
//   enq, deq, kvi             - requests from the scheduler front end
//   kvo, empty, full, busy,
//   count, err                - head entry and status from the queue
// master = front end, slave = queue.
interface ra_pq_gen_if #(
    parameter int unsigned CAPACITY = 16,
    parameter int unsigned KEY_W    = 16,
    parameter int unsigned VAL_W    = 16
);
    localparam int unsigned CW = $clog2(CAPACITY + 1);

    logic                   enq;
    logic                   deq;
    logic [KEY_W+VAL_W-1:0] kvi;
    logic [KEY_W+VAL_W-1:0] kvo;
    logic                   empty;
    logic                   full;
    logic                   busy;
    logic [CW-1:0]          count;
    logic                   err;

    modport master (
        output enq, deq, kvi,
        input  kvo, empty, full, busy, count, err
    );

    modport slave (
        input  enq, deq, kvi,
        output kvo, empty, full, busy, count, err
    );
endinterface

// File: rtl/ra_pq_gen_cas.sv
// ra_pq_cas: combinational compare-and-swap of two {valid, key, value}
// entries. The better entry leaves on lo_o (lower slot index).
//   a_i  - entry currently at the lower index
//   b_i  - entry currently at the higher index
//   lo_o - better of the two (a_i on a tie)
//   hi_o - the other one
module ra_pq_cas
    import ra_pq_gen_pkg::*;
#(
    parameter int unsigned KEY_W     = 16,
    parameter int unsigned VAL_W     = 16,
    parameter int unsigned MAX_FIRST = 0
) (
    input  logic [KEY_W+VAL_W:0] a_i,
    input  logic [KEY_W+VAL_W:0] b_i,
    output logic [KEY_W+VAL_W:0] lo_o,
    output logic [KEY_W+VAL_W:0] hi_o
);
    localparam int unsigned VB = KEY_W + VAL_W;   // valid bit position

    logic swap;

    always_comb begin
        swap = pq_better(b_i[VB], PQ_KEY_MAX_W'(b_i[VB-1:VAL_W]),
                         a_i[VB], PQ_KEY_MAX_W'(a_i[VB-1:VAL_W]),
                         MAX_FIRST != 0);
        lo_o = swap ? b_i : a_i;
        hi_o = swap ? a_i : b_i;
    end
endmodule

// File: rtl/ra_pq_gen.sv
// ra_pq_gen: parametrised register-array min/max priority queue.
//   clk, rst - clock, synchronous active-high reset
//   pq       - slave side of ra_pq_gen_if:
//              enq/deq/kvi requests; kvo head entry (0 when empty),
//              empty, full, busy (ops ignored this cycle), count, err pulse.
// Each accepted op goes through a front mux (push/replace/pop) followed by an
// odd-pair compare stage (A) and an even-pair compare stage (B). In the
// two-phase mode A and B are registered on alternate cycles and share one
// bank of compare-and-swap cells.
module ra_pq_gen
    import ra_pq_gen_pkg::*;
#(
    parameter int unsigned CAPACITY  = 16,
    parameter int unsigned KEY_W     = 16,
    parameter int unsigned VAL_W     = 16,
    parameter int unsigned TWO_PHASE = 1,
    parameter int unsigned MAX_FIRST = 0
) (
    input  logic        clk,
    input  logic        rst,
    ra_pq_gen_if.slave  pq
);
    localparam int unsigned EW   = 1 + KEY_W + VAL_W;
    localparam int unsigned CW   = $clog2(CAPACITY + 1);
    localparam int unsigned NP   = CAPACITY / 2;
    localparam pq_mode_e    MODE = (TWO_PHASE != 0) ? PQ_TWO_PHASE : PQ_SINGLE;

    if ((CAPACITY < 2) || (CAPACITY % 2 != 0)) begin : g_cap_chk
        $error("ra_pq_gen: CAPACITY must be even and >= 2");
    end
    if (KEY_W > PQ_KEY_MAX_W) begin : g_key_chk
        $error("ra_pq_gen: KEY_W exceeds PQ_KEY_MAX_W");
    end

    typedef struct packed {
        logic             v;
        logic [KEY_W-1:0] k;
        logic [VAL_W-1:0] d;
    } slot_t;

    // Index 0 is slot 1 (the head).
    slot_t         slot_q [CAPACITY];
    slot_t         slot_d [CAPACITY];
    slot_t         mux_s  [CAPACITY];
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, full_q;
    logic          err_q, err_d;
    pq_phase_e     phase_q, phase_d;

    logic  busy;
    logic  do_rep, do_push, do_pop;
    slot_t ins;

    // ---------------- phase FSM + op decode ----------------
    always_comb begin
        phase_d = PH_ACCEPT;
        if (MODE == PQ_TWO_PHASE && phase_q == PH_ACCEPT) begin
            phase_d = PH_SORT;
        end

        busy    = (phase_q == PH_SORT);
        do_rep  = !busy && pq.enq && pq.deq && !empty_q;
        do_push = !busy && pq.enq && (!pq.deq || empty_q) && !full_q;
        do_pop  = !busy && pq.deq && !pq.enq && !empty_q;

        if (busy) begin
            err_d = pq.enq || pq.deq;
        end else begin
            err_d = (pq.enq && !pq.deq && full_q) || (pq.deq && !pq.enq && empty_q);
        end

        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // ---------------- front mux ----------------
    always_comb begin
        logic hole;
        ins.v = 1'b1;
        ins.k = pq.kvi[KEY_W+VAL_W-1:VAL_W];
        ins.d = pq.kvi[VAL_W-1:0];
        hole  = 1'b0;
        for (int unsigned i = 0; i < CAPACITY; i++) begin
            mux_s[i] = slot_q[i];
        end
        if (do_push) begin
            // Pops leave invalid holes that sink only one slot per op, so
            // the tail can still be valid when count < CAPACITY. The shift
            // stops at the first hole, which absorbs it; nothing valid is
            // pushed off the end.
            mux_s[0] = ins;
            for (int unsigned i = 1; i < CAPACITY; i++) begin
                hole     = hole || !slot_q[i-1].v;
                mux_s[i] = hole ? slot_q[i] : slot_q[i-1];
            end
        end else if (do_rep) begin
            mux_s[0] = ins;
        end else if (do_pop) begin
            mux_s[0].v = 1'b0;
        end
    end

    // ---------------- compare stages ----------------
    if (MODE == PQ_SINGLE) begin : g_single
        logic [EW-1:0] a_lo [NP];
        logic [EW-1:0] a_hi [NP];
        slot_t         sa   [CAPACITY];

        for (genvar j = 0; j < NP; j++) begin : g_a
            ra_pq_cas #(
                .KEY_W     (KEY_W),
                .VAL_W     (VAL_W),
                .MAX_FIRST (MAX_FIRST)
            ) u_cas (
                .a_i  (mux_s[2*j]),
                .b_i  (mux_s[2*j+1]),
                .lo_o (a_lo[j]),
                .hi_o (a_hi[j])
            );
        end

        always_comb begin
            for (int unsigned j = 0; j < NP; j++) begin
                sa[2*j]   = a_lo[j];
                sa[2*j+1] = a_hi[j];
            end
        end

        if (NP > 1) begin : g_b
            logic [EW-1:0] b_lo [NP-1];
            logic [EW-1:0] b_hi [NP-1];

            for (genvar j = 0; j < NP - 1; j++) begin : g_cas
                ra_pq_cas #(
                    .KEY_W     (KEY_W),
                    .VAL_W     (VAL_W),
                    .MAX_FIRST (MAX_FIRST)
                ) u_cas (
                    .a_i  (sa[2*j+1]),
                    .b_i  (sa[2*j+2]),
                    .lo_o (b_lo[j]),
                    .hi_o (b_hi[j])
                );
            end

            always_comb begin
                slot_d[0]          = sa[0];
                slot_d[CAPACITY-1] = sa[CAPACITY-1];
                for (int unsigned j = 0; j < NP - 1; j++) begin
                    slot_d[2*j+1] = b_lo[j];
                    slot_d[2*j+2] = b_hi[j];
                end
            end
        end else begin : g_nob
            always_comb begin
                for (int unsigned i = 0; i < CAPACITY; i++) begin
                    slot_d[i] = sa[i];
                end
            end
        end
    end else begin : g_two
        // One bank of NP cells: odd pairs of the mux output on PH_ACCEPT,
        // even pairs of the stored slots on PH_SORT (last cell idle there).
        logic [EW-1:0] c_a  [NP];
        logic [EW-1:0] c_b  [NP];
        logic [EW-1:0] c_lo [NP];
        logic [EW-1:0] c_hi [NP];

        always_comb begin
            for (int unsigned j = 0; j < NP; j++) begin
                if (phase_q == PH_ACCEPT) begin
                    c_a[j] = mux_s[2*j];
                    c_b[j] = mux_s[2*j+1];
                end else if (j < NP - 1) begin
                    c_a[j] = slot_q[2*j+1];
                    c_b[j] = slot_q[2*j+2];
                end else begin
                    c_a[j] = slot_q[2*j];
                    c_b[j] = slot_q[2*j+1];
                end
            end
        end

        for (genvar j = 0; j < NP; j++) begin : g_cas
            ra_pq_cas #(
                .KEY_W     (KEY_W),
                .VAL_W     (VAL_W),
                .MAX_FIRST (MAX_FIRST)
            ) u_cas (
                .a_i  (c_a[j]),
                .b_i  (c_b[j]),
                .lo_o (c_lo[j]),
                .hi_o (c_hi[j])
            );
        end

        always_comb begin
            for (int unsigned i = 0; i < CAPACITY; i++) begin
                slot_d[i] = slot_q[i];
            end
            if (phase_q == PH_ACCEPT) begin
                for (int unsigned j = 0; j < NP; j++) begin
                    slot_d[2*j]   = c_lo[j];
                    slot_d[2*j+1] = c_hi[j];
                end
            end else begin
                for (int unsigned j = 0; j < NP - 1; j++) begin
                    slot_d[2*j+1] = c_lo[j];
                    slot_d[2*j+2] = c_hi[j];
                end
            end
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CAPACITY; i++) begin
                slot_q[i] <= '0;
            end
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            phase_q <= PH_ACCEPT;
        end else begin
            for (int unsigned i = 0; i < CAPACITY; i++) begin
                slot_q[i] <= slot_d[i];
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(CAPACITY));
            err_q   <= err_d;
            phase_q <= phase_d;
        end
    end

    assign pq.kvo   = slot_q[0].v ? {slot_q[0].k, slot_q[0].d} : '0;
    assign pq.count = count_q;
    assign pq.empty = empty_q;
    assign pq.full  = full_q;
    assign pq.err   = err_q;
    assign pq.busy  = busy;

endmodule

// File: doc/ra_pq_gen.md
# ra_pq_gen

Parametrised register-array min/max priority queue. It generalises the team's fixed-width, two-phase register-array queue with four additions: configurable key/value widths, an elaboration-time choice between single-cycle and alternating-cycle operation, min- or max-first ordering, and per-slot valid bits so the full key range is usable (no sentinel key). It sits behind the scheduler front end as a drop-in for the existing `pq_if` devices and adds an occupancy count and an error strobe.

## Interface
- `CAPACITY`, 16, number of slots; must be even and ≥2; an odd value is an elaboration `$error`.
- `KEY_W`, 16, key width in bits.
- `VAL_W`, 16, value width in bits.
- `TWO_PHASE`, 1, operating mode.
  - 1: one compare stage per cycle; ops are accepted every other cycle.
  - 0: both compare stages in one cycle; ops are accepted every cycle.
- `MAX_FIRST`, 0, ordering: 0 = smallest key at the head, 1 = largest key at the head.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `enq` in 1: enqueue request.
- `deq` in 1: dequeue request.
- `kvi` in KEY_W+VAL_W: key in the upper bits, value in the lower bits.
- `kvo` out KEY_W+VAL_W: head entry; 0 when empty.
- `empty` out 1: no valid slot.
- `full` out 1: all slots valid.
- `busy` out 1: ops ignored this cycle; always 0 when TWO_PHASE=0.
- `count` out $clog2(CAPACITY+1): number of valid entries.
- `err` out 1: one-cycle pulse flagging an illegal or ignored request.

## Operation
- Storage is slots 1..CAPACITY, each holding {valid, key, value}.
- An invalid slot compares as worse than any valid key in both orderings.
- Effective operation, decoded on a cycle with busy=0:
  - replace = enq & deq & !empty: slot 1 ← kvi. Legal when full.
  - push = enq & !deq & !full: every slot i ← slot i-1, slot 1 ← kvi.
  - pop = deq & !enq & !empty: slot 1 ← invalid.
  - enq & deq & empty: treated as push.
  - enq & !deq & full: dropped, err=1.
  - deq & !enq & empty: ignored, err=1.
- Stage A: compare-and-swap on the odd pairs (1,2), (3,4), …; better entry goes to the lower index.
- Stage B: compare-and-swap on the even pairs (2,3), (4,5), …, (CAPACITY-2, CAPACITY-1). Slots 1 and CAPACITY pass through unchanged.
- TWO_PHASE=0: mux, stage A and stage B are one combinational path and are registered every cycle.
- TWO_PHASE=1: mux and stage A are registered on phase 0; stage B alone is registered on phase 1.
  - The phase bit clears on rst and then toggles every cycle; busy = phase.
  - Requests on busy cycles are ignored, do not change count, and assert err=1 when enq or deq is high.
- Ties between equal valid keys: no swap. Dequeue order among equal keys is unspecified.
- count: +1 on push, −1 on pop, unchanged on replace and on ignored requests.
- empty = (count==0), full = (count==CAPACITY), both registered alongside count.
- kvo is slot 1 when it is valid, else 0.

## Timing
- Reset:
  - all slots invalid, count=0, empty=1, full=0, kvo=0, err=0, busy=0;
  - in TWO_PHASE=1 the first accepted cycle is the one right after rst deasserts.
- All outputs are registered. An op accepted at edge N is reflected in kvo, count, empty and full after edge N.
- kvo is the true best entry whenever busy=0.
- Throughput: 1 op/cycle when TWO_PHASE=0; 1 op per 2 cycles when TWO_PHASE=1.
- err is asserted in the cycle after the offending request, for exactly one cycle.
- rst during any phase returns to the reset state at the next edge; any in-flight stage B is discarded.

## Structure
- `pq_pkg` additions:
  - `pq_mode_e` {PQ_SINGLE, PQ_TWO_PHASE};
  - function `pq_better(va, ka, vb, kb, max_first)` returning 1 when entry a should go to the lower index.
- Slot type is a local packed struct, since widths are parameters.
- One sub-module, `ra_pq_cas`: combinational compare-and-swap of two {valid, key, value} entries, parametrised by KEY_W, VAL_W and MAX_FIRST. It is instantiated CAPACITY/2 + CAPACITY/2−1 times when TWO_PHASE=0, and CAPACITY/2 times (shared across phases) when TWO_PHASE=1.

## Test plan
- Min mode, CAPACITY=8, TWO_PHASE=0: push keys 5,3,7,1 on consecutive cycles → kvo key 1, count=4; four pops → keys 1,3,5,7, then empty=1, kvo=0.
- Full and overflow, CAPACITY=4: push 9,8,7,6 → full=1; push 2 → err pulse, count stays 4; replace with key 2 → kvo key 2, count=4.
- Empty underflow: deq on an empty queue → err=1 for one cycle, count=0; enq & deq of key 4 on an empty queue → count=1, kvo key 4.
- TWO_PHASE=1: enq key 3 on a busy cycle → err=1 and ignored; on the next cycle it is accepted; busy alternates 0,1,0,… from reset.
- MAX_FIRST=1 with key 0xFFFF: push 0x0000, 0xFFFF, 0x8000 → pops return 0xFFFF, 0x8000, 0x0000, showing the full key range is usable.
- Random enq/deq/replace for 10k cycles against a sorted-list model, both modes, with rst asserted mid-run → kvo and count match the model every non-busy cycle.
